mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter sharing the single-port data/instruction memory of the 8-bit CPU between three requesters: instruction fetch (port 0), load/store unit (port 1), debug/loader port (port 2). It sits inside `top_level` between the requesters and the memory. It latches one request at a time, drives the memory handshake until `mem_ready`, and returns read data with a one-cycle done pulse. A stalled memory access is aborted by a watchdog.

## Interface
- `SIZE`, 8, data width in bits.
- `ADDR_W`, 8, address width in bits.
- `TIMEOUT`, 16, max BUSY cycles without `mem_ready` before abort; 0 disables the watchdog; legal range 0..255.

- `clk`  in  1  system clock; all logic on rising edge.
- `rstn`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `req`  in  3  per-port request; bit i = port i.
- `we`  in  3  per-port write enable (1 = write).
- `lock`  in  3  per-port bus-lock request (used only with `ARB_LOCK_EN`).
- `addr`  in  3*ADDR_W  packed addresses; port i at `[i*ADDR_W +: ADDR_W]`.
- `wdata`  in  3*SIZE  packed write data; port i at `[i*SIZE +: SIZE]`.
- `gnt`  out  3  one-hot current owner; 0 when idle.
- `done`  out  3  one-cycle completion pulse to owner.
- `err`  out  3  one-cycle timeout-abort pulse to owner.
- `rdata`  out  SIZE  read data of the last completed read.
- `mem_en`  out  1  memory access strobe, held until accepted.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  SIZE  memory write data.
- `mem_rdata`  in  SIZE  memory read data, valid when `mem_ready`=1.
- `mem_ready`  in  1  memory accepts/completes the access this cycle.

## Operation
- FSM has two states: IDLE and BUSY. Reset state is IDLE.
- Round-robin pointer `ptr` (2 bits, values 0..2) resets to 0.
- IDLE:
  - If any `req` is set, the winner is the first set bit scanning `ptr`, `ptr+1`, `ptr+2` (mod 3).
  - On the clock edge: latch the winner's `we`/`addr`/`wdata` into `mem_we`/`mem_addr`/`mem_wdata`, set `gnt` one-hot, set `mem_en`=1, go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - `mem_en` and the latched command are held stable.
  - On `mem_ready`=1: pulse `done[owner]`; for a read, load `rdata` from `mem_rdata`; for a write, leave `rdata` unchanged. Then clear `mem_en` and `gnt`, set `ptr` = owner+1 mod 3, and go to IDLE.
- Requester inputs are ignored while in BUSY. Dropping `req` mid-access does not cancel the access.
- A requester holds `req` until it sees `done` or `err`. A `req` still high in the IDLE cycle after `done` is a new request.
- Watchdog:
  - An 8-bit counter clears on entry to BUSY and increments on each BUSY cycle with `mem_ready`=0.
  - When it reaches `TIMEOUT` (nonzero): pulse `err[owner]`, no `done`, `rdata` unchanged, `mem_en`=0, `ptr` advances, go to IDLE.
  - If `mem_ready` and the timeout occur in the same cycle, `mem_ready` wins: the access completes normally.
- Reset mid-access: the access is abandoned. All outputs return to reset values on the next edge, and no `done`/`err` is issued.
- Reset values: `gnt`=0, `done`=0, `err`=0, `rdata`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.

## Timing
- Request sampled in IDLE cycle N → `gnt`/`mem_en` high in N+1.
- `mem_ready` high in cycle M → `done` and `rdata` valid in M+1, with `gnt`/`mem_en` low in M+1.
- Zero-wait memory: `done` arrives 2 cycles after request sampling.
- Back-to-back throughput is one access per 2 cycles minimum, because M+1 is an IDLE/arbitration cycle.
- `done`/`err` are exactly one cycle wide.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `ARB_LOCK_EN` defined:
  - On completion, if `lock[owner]`=1 and `req[owner]`=1 in the IDLE cycle that follows, the owner is re-granted ahead of all others.
  - `ptr` is not advanced while the lock chain continues.
  - A timeout abort breaks the lock.
- `ARB_LOCK_EN` undefined: `lock` is ignored and arbitration is pure round-robin.

## Test plan
- Single read: port 0 reads addr 0x10, memory ready 1 cycle after `mem_en`, `mem_rdata`=0xA5 → `gnt`=3'b001 for 2 cycles, `done[0]` pulse, `rdata`=0xA5.
- Contention: `req`=3'b111 held continuously, zero-wait memory → grant order 0,1,2,0; `done` every 2 cycles.
- Write keeps `rdata`: port 1 writes 0x3C to 0x20 after a read returned 0x55 → `mem_we`=1, `mem_wdata`=0x3C, `rdata` stays 0x55, `done[1]` pulse.
- Watchdog: `TIMEOUT`=16, `mem_ready` held low → `err[owner]` pulse after 16 BUSY cycles, no `done`, `mem_en` low next cycle. With `TIMEOUT`=0, no abort after 300 cycles.
- Reset mid-access: `rstn`=0 during BUSY → next edge all outputs 0, `ptr`=0; the following request from port 2 with port 0 idle is granted to port 2.
- Lock (`ARB_LOCK_EN`): port 1 `lock`=1 and `req`=1 with port 2 also requesting → port 1 granted 3 times consecutively; after `lock` drops, port 2 is granted next.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and memory handshake bundle for mem_arbiter.
// The arbiter uses the slave modport; the surrounding system uses master.
interface mem_arbiter_if #(
    parameter int SIZE   = 8,
    parameter int ADDR_W = 8
);
    logic [2:0]          req;
    logic [2:0]          we;
    logic [2:0]          lock;
    logic [3*ADDR_W-1:0] addr;
    logic [3*SIZE-1:0]   wdata;
    logic [2:0]          gnt;
    logic [2:0]          done;
    logic [2:0]          err;
    logic [SIZE-1:0]     rdata;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [SIZE-1:0]     mem_wdata;
    logic [SIZE-1:0]     mem_rdata;
    logic                mem_ready;

    modport slave (
        input  req, we, lock, addr, wdata, mem_rdata, mem_ready,
        output gnt, done, err, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, we, lock, addr, wdata, mem_rdata, mem_ready,
        input  gnt, done, err, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Three-port round-robin arbiter for the shared single-port memory, with a stall watchdog.
// Optional owner bus-lock re-grant is enabled by defining ARB_LOCK_EN.
module mem_arbiter #(
    parameter int SIZE    = 8,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rstn,
    mem_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state, state_nx;
    logic [1:0]        ptr, ptr_nx;
    logic [1:0]        owner, owner_nx;
    logic [1:0]        win;
    logic              found;
    logic [7:0]        wdog, wdog_nx;
    logic [2:0]        gnt_q, gnt_nx;
    logic [2:0]        done_q, done_nx;
    logic [2:0]        err_q, err_nx;
    logic [SIZE-1:0]   rdata_q, rdata_nx;
    logic              mem_en_q, mem_en_nx;
    logic              mem_we_q, mem_we_nx;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_nx;
    logic [SIZE-1:0]   mem_wdata_q, mem_wdata_nx;
    logic              lock_hold, lock_hold_nx;

    function automatic logic [1:0] wrap3(input logic [1:0] p, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, p} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Scan from the farthest candidate to the nearest so the nearest set request wins.
    always_comb begin
        win   = ptr;
        found = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (bus.req[wrap3(ptr, 2'(k))]) begin
                win   = wrap3(ptr, 2'(k));
                found = 1'b1;
            end
        end
`ifdef ARB_LOCK_EN
        if (lock_hold && bus.req[owner] && bus.lock[owner]) begin
            win   = owner;
            found = 1'b1;
        end
`endif
    end

`ifndef ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^{bus.lock, lock_hold};
`endif

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        owner_nx     = owner;
        wdog_nx      = wdog;
        gnt_nx       = gnt_q;
        done_nx      = '0;
        err_nx       = '0;
        rdata_nx     = rdata_q;
        mem_en_nx    = mem_en_q;
        mem_we_nx    = mem_we_q;
        mem_addr_nx  = mem_addr_q;
        mem_wdata_nx = mem_wdata_q;
        lock_hold_nx = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx     = BUSY;
                    owner_nx     = win;
                    gnt_nx       = 3'b001 << win;
                    mem_en_nx    = 1'b1;
                    mem_we_nx    = bus.we[win];
                    mem_addr_nx  = bus.addr[win*ADDR_W +: ADDR_W];
                    mem_wdata_nx = bus.wdata[win*SIZE +: SIZE];
                    wdog_nx      = '0;
                end
            end
            BUSY: begin
                // mem_ready takes priority over a watchdog expiry in the same cycle.
                if (bus.mem_ready) begin
                    done_nx      = gnt_q;
                    if (!mem_we_q) rdata_nx = bus.mem_rdata;
                    state_nx     = IDLE;
                    gnt_nx       = '0;
                    mem_en_nx    = 1'b0;
                    ptr_nx       = wrap3(owner, 2'd1);
                    lock_hold_nx = 1'b1;
                end else if (TIMEOUT != 0 && ({1'b0, wdog} + 9'd1) == 9'(TIMEOUT)) begin
                    err_nx    = gnt_q;
                    state_nx  = IDLE;
                    gnt_nx    = '0;
                    mem_en_nx = 1'b0;
                    ptr_nx    = wrap3(owner, 2'd1);
                end else begin
                    wdog_nx = wdog + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            wdog        <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            lock_hold   <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            owner       <= owner_nx;
            wdog        <= wdog_nx;
            gnt_q       <= gnt_nx;
            done_q      <= done_nx;
            err_q       <= err_nx;
            rdata_q     <= rdata_nx;
            mem_en_q    <= mem_en_nx;
            mem_we_q    <= mem_we_nx;
            mem_addr_q  <= mem_addr_nx;
            mem_wdata_q <= mem_wdata_nx;
            lock_hold   <= lock_hold_nx;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: one DUT with the watchdog at 16,
// a second with the watchdog disabled.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.SIZE(8), .ADDR_W(8)) bus ();
    mem_arbiter_if #(.SIZE(8), .ADDR_W(8)) bus0 ();

    mem_arbiter #(.SIZE(8), .ADDR_W(8), .TIMEOUT(16)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    mem_arbiter #(.SIZE(8), .ADDR_W(8), .TIMEOUT(0)) dut_nowd (
        .clk (clk),
        .rstn(rstn),
        .bus (bus0.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.gnt, bus.done, bus.err} !== 9'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_ctrl: got gnt=%b done=%b err=%b want all 0", bus.gnt, bus.done, bus.err);
        end
        n_cmp++;
        if ({bus.rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 26'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_data: got rdata=%h en=%b we=%b addr=%h wdata=%h want all 0",
                     bus.rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        rstn = 1'b1;
    endtask

    task automatic test_single_read();
        bus.req = 3'b001;
        bus.we  = 3'b000;
        bus.addr[7:0] = 8'h10;
        tick();
        n_cmp++;
        if ({bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {3'b001, 1'b1, 1'b0, 8'h10}) begin
            n_bad++;
            $display("[TB] FAIL read_grant: got gnt=%b en=%b we=%b addr=%h want 001 1 0 10",
                     bus.gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        tick();
        n_cmp++;
        if ({bus.gnt, bus.mem_en, bus.done} !== {3'b001, 1'b1, 3'b000}) begin
            n_bad++;
            $display("[TB] FAIL read_hold: got gnt=%b en=%b done=%b want 001 1 000", bus.gnt, bus.mem_en, bus.done);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 8'hA5;
        tick();
        n_cmp++;
        if ({bus.done, bus.rdata, bus.gnt, bus.mem_en} !== {3'b001, 8'hA5, 3'b000, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL read_done: got done=%b rdata=%h gnt=%b en=%b want 001 a5 000 0",
                     bus.done, bus.rdata, bus.gnt, bus.mem_en);
        end
        bus.req       = 3'b000;
        bus.mem_ready = 1'b0;
        tick();
        n_cmp++;
        if ({bus.done, bus.gnt} !== 6'd0) begin
            n_bad++;
            $display("[TB] FAIL read_pulse: got done=%b gnt=%b want 000 000", bus.done, bus.gnt);
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp_gnt  [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        logic [2:0] exp_done [7] = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        rstn = 1'b0;
        tick();
        rstn          = 1'b1;
        bus.req       = 3'b111;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 8'h11;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_cmp++;
            if ({bus.gnt, bus.done} !== {exp_gnt[i], exp_done[i]}) begin
                n_bad++;
                $display("[TB] FAIL contention_%0d: got gnt=%b done=%b want gnt=%b done=%b",
                         i, bus.gnt, bus.done, exp_gnt[i], exp_done[i]);
            end
        end
        bus.req = 3'b000;
        tick();
        bus.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_write_keeps_rdata();
        bus.req        = 3'b010;
        bus.we         = 3'b000;
        bus.addr[15:8] = 8'h30;
        bus.mem_ready  = 1'b1;
        bus.mem_rdata  = 8'h55;
        tick();
        tick();
        n_cmp++;
        if ({bus.done, bus.rdata} !== {3'b010, 8'h55}) begin
            n_bad++;
            $display("[TB] FAIL wr_preread: got done=%b rdata=%h want 010 55", bus.done, bus.rdata);
        end
        bus.we          = 3'b010;
        bus.addr[15:8]  = 8'h20;
        bus.wdata[15:8] = 8'h3C;
        bus.mem_rdata   = 8'hEE;
        tick();
        n_cmp++;
        if ({bus.gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {3'b010, 1'b1, 8'h20, 8'h3C}) begin
            n_bad++;
            $display("[TB] FAIL wr_cmd: got gnt=%b we=%b addr=%h wdata=%h want 010 1 20 3c",
                     bus.gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        n_cmp++;
        if ({bus.done, bus.rdata} !== {3'b010, 8'h55}) begin
            n_bad++;
            $display("[TB] FAIL wr_rdata: got done=%b rdata=%h want 010 55", bus.done, bus.rdata);
        end
        bus.req       = 3'b000;
        bus.we        = 3'b000;
        bus.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        bus.req = 3'b001;
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_cmp++;
            if ({bus.gnt, bus.mem_en, bus.err, bus.done} !== {3'b001, 1'b1, 3'b000, 3'b000}) begin
                n_bad++;
                $display("[TB] FAIL wd_wait_%0d: got gnt=%b en=%b err=%b done=%b want 001 1 000 000",
                         i, bus.gnt, bus.mem_en, bus.err, bus.done);
            end
        end
        tick();
        n_cmp++;
        if ({bus.err, bus.done, bus.gnt, bus.mem_en, bus.rdata} !== {3'b001, 3'b000, 3'b000, 1'b0, 8'h55}) begin
            n_bad++;
            $display("[TB] FAIL wd_abort: got err=%b done=%b gnt=%b en=%b rdata=%h want 001 000 000 0 55",
                     bus.err, bus.done, bus.gnt, bus.mem_en, bus.rdata);
        end
        bus.req = 3'b000;
        tick();
        n_cmp++;
        if (bus.err !== 3'b000) begin
            n_bad++;
            $display("[TB] FAIL wd_pulse: got err=%b want 000", bus.err);
        end
    endtask

    task automatic test_reset_mid_access();
        bus.req = 3'b010;
        tick();
        n_cmp++;
        if (bus.gnt !== 3'b010) begin
            n_bad++;
            $display("[TB] FAIL rst_pre_gnt: got %b want 010", bus.gnt);
        end
        rstn    = 1'b0;
        bus.req = 3'b000;
        tick();
        n_cmp++;
        if ({bus.gnt, bus.done, bus.err, bus.rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 35'd0) begin
            n_bad++;
            $display("[TB] FAIL rst_mid: got gnt=%b done=%b err=%b rdata=%h en=%b we=%b addr=%h wdata=%h want all 0",
                     bus.gnt, bus.done, bus.err, bus.rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        rstn    = 1'b1;
        bus.req = 3'b100;
        tick();
        n_cmp++;
        if ({bus.gnt, bus.done, bus.err} !== {3'b100, 3'b000, 3'b000}) begin
            n_bad++;
            $display("[TB] FAIL rst_regrant: got gnt=%b done=%b err=%b want 100 000 000", bus.gnt, bus.done, bus.err);
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.req       = 3'b000;
        bus.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_lock();
        bus.req       = 3'b110;
        bus.lock      = 3'b010;
        bus.mem_ready = 1'b1;
`ifdef ARB_LOCK_EN
        for (int g = 0; g < 3; g++) begin
            tick();
            n_cmp++;
            if (bus.gnt !== 3'b010) begin
                n_bad++;
                $display("[TB] FAIL lock_gnt_%0d: got %b want 010", g, bus.gnt);
            end
            if (g == 2) bus.lock = 3'b000;
            tick();
            n_cmp++;
            if (bus.done !== 3'b010) begin
                n_bad++;
                $display("[TB] FAIL lock_done_%0d: got %b want 010", g, bus.done);
            end
        end
`else
        tick();
        n_cmp++;
        if (bus.gnt !== 3'b010) begin
            n_bad++;
            $display("[TB] FAIL nolock_gnt: got %b want 010", bus.gnt);
        end
        tick();
`endif
        tick();
        n_cmp++;
        if (bus.gnt !== 3'b100) begin
            n_bad++;
            $display("[TB] FAIL lock_release: got %b want 100", bus.gnt);
        end
        bus.req  = 3'b000;
        bus.lock = 3'b000;
        tick();
        bus.mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_no_timeout();
        bus0.req = 3'b001;
        for (int i = 0; i < 300; i++) begin
            tick();
            n_cmp++;
            if ({bus0.err, bus0.done} !== 6'd0) begin
                n_bad++;
                $display("[TB] FAIL nowd_%0d: got err=%b done=%b want 000 000", i, bus0.err, bus0.done);
            end
        end
        n_cmp++;
        if ({bus0.gnt, bus0.mem_en} !== {3'b001, 1'b1}) begin
            n_bad++;
            $display("[TB] FAIL nowd_hold: got gnt=%b en=%b want 001 1", bus0.gnt, bus0.mem_en);
        end
    endtask

    initial begin
        rstn           = 1'b0;
        bus.req        = '0;
        bus.we         = '0;
        bus.lock       = '0;
        bus.addr       = '0;
        bus.wdata      = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        bus0.req       = '0;
        bus0.we        = '0;
        bus0.lock      = '0;
        bus0.addr      = '0;
        bus0.wdata     = '0;
        bus0.mem_rdata = '0;
        bus0.mem_ready = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_write_keeps_rdata();
        test_watchdog();
        test_reset_mid_access();
        test_lock();
        test_no_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
